// File: rtl/tnoc_pkg.sv
// Shared types and helpers for the tnoc packet arbiter.
//   tnoc_arbiter_state : arbiter FSM state (IDLE = arbitrating, LOCKED = packet in flight)
//   sel_width()        : width of a binary index into N requesters, minimum 1
package tnoc_pkg;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } tnoc_arbiter_state;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tnoc_round_robin_picker.sv
// Combinational round-robin pick: returns the first set bit of i_request found
// searching upward from i_pointer, wrapping REQUESTS-1 -> 0.
//   i_request : request vector
//   i_pointer : binary index of the highest-priority requester (< REQUESTS)
//   o_pick    : one-hot pick, all-zero when no request
module tnoc_round_robin_picker #(
  parameter int unsigned REQUESTS = 5,
  parameter int unsigned SEL_W    = 3
) (
  input  logic [REQUESTS-1:0] i_request,
  input  logic [SEL_W-1:0]    i_pointer,
  output logic [REQUESTS-1:0] o_pick
);

  logic [REQUESTS-1:0] w_mask;
  logic [REQUESTS-1:0] w_masked;
  logic [REQUESTS-1:0] w_lo_masked;
  logic [REQUESTS-1:0] w_lo_all;

  // Bits at or above the pointer; the lowest such request wins, otherwise wrap
  // around and take the lowest request overall.
  assign w_mask      = ~((REQUESTS'(1) << i_pointer) - REQUESTS'(1));
  assign w_masked    = i_request & w_mask;
  // x & -x isolates the lowest set bit.
  assign w_lo_masked = w_masked & (~w_masked + REQUESTS'(1));
  assign w_lo_all    = i_request & (~i_request + REQUESTS'(1));
  assign o_pick      = (|w_masked) ? w_lo_masked : w_lo_all;

endmodule

// File: rtl/tnoc_packet_arbiter.sv
// Packet-granular round-robin arbiter for one router output port.
// A grant taken on a head flit is held until the tail flit is accepted, so
// packets never interleave on the link.
//   clk       : router clock
//   rst_n     : synchronous active-low reset
//   i_request : per requester, a flit is valid and targets this port
//   i_tail    : per requester, its current flit is the tail
//   i_ready   : downstream accepts a flit this cycle
//   o_grant   : one-hot grant (all-zero = none)
//   o_select  : binary index of o_grant, 0 when no grant
//   o_valid   : granted requester is presenting a flit
//   o_busy    : a multi-flit packet holds the port
module tnoc_packet_arbiter
  import tnoc_pkg::*;
#(
  parameter  int unsigned REQUESTS = 5,
  localparam int unsigned SEL_W    = sel_width(REQUESTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQUESTS-1:0] i_request,
  input  logic [REQUESTS-1:0] i_tail,
  input  logic                i_ready,
  output logic [REQUESTS-1:0] o_grant,
  output logic [SEL_W-1:0]    o_select,
  output logic                o_valid,
  output logic                o_busy
);

  tnoc_arbiter_state   r_state;
  tnoc_arbiter_state   w_state_next;
  logic [REQUESTS-1:0] r_grant;
  logic [REQUESTS-1:0] w_grant_next;
  logic [SEL_W-1:0]    r_pointer;
  logic [SEL_W-1:0]    w_pointer_next;
  logic [SEL_W-1:0]    w_pointer_inc;
  logic [REQUESTS-1:0] w_pick;
  logic [REQUESTS-1:0] w_grant;
  logic [SEL_W-1:0]    w_select;
  logic                w_transfer;
  logic                w_tail;

  tnoc_round_robin_picker #(
    .REQUESTS (REQUESTS),
    .SEL_W    (SEL_W)
  ) u_picker (
    .i_request (i_request),
    .i_pointer (r_pointer),
    .o_pick    (w_pick)
  );

  // Outputs are forced idle while reset is asserted, even though the IDLE
  // grant path is otherwise purely combinational from i_request.
  assign w_grant    = !rst_n            ? '0      :
                      (r_state == LOCKED) ? r_grant : w_pick;
  assign o_grant    = w_grant;
  assign o_valid    = |(w_grant & i_request);
  assign o_busy     = rst_n && (r_state == LOCKED);
  assign w_transfer = o_valid && i_ready;
  // Only the granted requester's tail bit matters.
  assign w_tail     = |(w_grant & i_tail);

  always_comb begin
    w_select = '0;
    for (int i = 0; i < REQUESTS; i++) begin
      if (w_grant[i]) begin
        w_select = w_select | SEL_W'(i);
      end
    end
  end
  assign o_select = w_select;

  // Next priority goes to the requester just after the one served.
  assign w_pointer_inc = (w_select == SEL_W'(REQUESTS - 1)) ? '0 : w_select + SEL_W'(1);

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_pointer_next = r_pointer;
    unique case (r_state)
      IDLE: begin
        if (w_transfer) begin
          w_pointer_next = w_pointer_inc;
          if (!w_tail) begin
            w_state_next = LOCKED;
            w_grant_next = w_grant;
          end
        end
      end
      LOCKED: begin
        if (w_transfer && w_tail) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_pointer <= '0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_pointer <= w_pointer_next;
    end
  end

endmodule

// File: tb/tb_tnoc_packet_arbiter.sv
// Self-checking bench for tnoc_packet_arbiter: a 4-requester instance and a
// 1-requester instance. Each row of a test table drives one cycle of inputs and
// pushes the expected outputs; they are popped and compared mid-cycle.
module tb_tnoc_packet_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req4, tail4;
  logic       ready4;
  logic [3:0] grant4;
  logic [1:0] sel4;
  logic       valid4, busy4;

  logic [0:0] req1, tail1;
  logic       ready1;
  logic [0:0] grant1;
  logic [0:0] sel1;
  logic       valid1, busy1;

  tnoc_packet_arbiter #(.REQUESTS(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_request (req4),
    .i_tail    (tail4),
    .i_ready   (ready4),
    .o_grant   (grant4),
    .o_select  (sel4),
    .o_valid   (valid4),
    .o_busy    (busy4)
  );

  tnoc_packet_arbiter #(.REQUESTS(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_request (req1),
    .i_tail    (tail1),
    .i_ready   (ready1),
    .o_grant   (grant1),
    .o_select  (sel1),
    .o_valid   (valid1),
    .o_busy    (busy1)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [1:0] enc4(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Row layout: {rst_n, req[3:0], tail[3:0], ready, exp_grant[3:0], exp_busy, exp_valid}
  task automatic drive_row4(input logic [15:0] r);
    exp_t e;
    @(posedge clk);
    #1;
    {rst_n, req4, tail4, ready4} = r[15:6];
    e.grant = r[5:2];
    e.sel   = enc4(r[5:2]);
    e.busy  = r[1];
    e.valid = r[0];
    sb_q.push_back(e);
  endtask

  // Granted requester must never drop its request mid-packet.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && busy4 === 1'b1 && (grant4 & req4) === 4'b0000) begin
      n_total++;
      $display("FAIL protocol: busy with grant=%b but req=%b", grant4, req4);
    end
  end

  task automatic test_reset();
    logic [15:0] tbl [3];
    exp_t e;
    tbl = '{16'b0_1111_1111_0_0000_0_0,
            16'b0_1111_1111_0_0000_0_0,
            16'b1_1111_1111_0_0001_0_1};
    for (int k = 0; k < 3; k++) begin
      drive_row4(tbl[k]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if ({grant4, sel4, busy4, valid4} !== e)
        $display("FAIL reset row %0d: got g=%b s=%0d b=%b v=%b, want g=%b s=%0d b=%b v=%b",
                 k, grant4, sel4, busy4, valid4, e.grant, e.sel, e.busy, e.valid);
      else n_pass++;
    end
  endtask

  task automatic test_single_flit();
    logic [15:0] tbl [5];
    exp_t e;
    tbl = '{16'b1_1111_1111_1_0001_0_1,
            16'b1_1111_1111_1_0010_0_1,
            16'b1_1111_1111_1_0100_0_1,
            16'b1_1111_1111_1_1000_0_1,
            16'b1_1111_1111_0_0001_0_1};
    for (int k = 0; k < 5; k++) begin
      drive_row4(tbl[k]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if ({grant4, sel4, busy4, valid4} !== e)
        $display("FAIL single_flit row %0d: got g=%b s=%0d b=%b v=%b, want g=%b s=%0d b=%b v=%b",
                 k, grant4, sel4, busy4, valid4, e.grant, e.sel, e.busy, e.valid);
      else n_pass++;
    end
  endtask

  task automatic test_multi_flit();
    logic [15:0] tbl [4];
    exp_t e;
    tbl = '{16'b1_0110_0000_1_0010_0_1,
            16'b1_0110_0000_1_0010_1_1,
            16'b1_0110_0010_1_0010_1_1,
            16'b1_0110_0100_0_0100_0_1};
    for (int k = 0; k < 4; k++) begin
      drive_row4(tbl[k]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if ({grant4, sel4, busy4, valid4} !== e)
        $display("FAIL multi_flit row %0d: got g=%b s=%0d b=%b v=%b, want g=%b s=%0d b=%b v=%b",
                 k, grant4, sel4, busy4, valid4, e.grant, e.sel, e.busy, e.valid);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [15:0] tbl [10];
    exp_t e;
    tbl = '{16'b1_0100_0100_1_0100_0_1,
            16'b1_1000_1000_1_1000_0_1,
            16'b1_0001_0000_1_0001_0_1,
            16'b1_1001_0000_0_0001_1_1,
            16'b1_1001_0000_0_0001_1_1,
            16'b1_1001_0000_0_0001_1_1,
            16'b1_1001_0000_0_0001_1_1,
            16'b1_1001_0000_0_0001_1_1,
            16'b1_1001_0001_1_0001_1_1,
            16'b1_1001_0000_0_1000_0_1};
    for (int k = 0; k < 10; k++) begin
      drive_row4(tbl[k]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if ({grant4, sel4, busy4, valid4} !== e)
        $display("FAIL stall row %0d: got g=%b s=%0d b=%b v=%b, want g=%b s=%0d b=%b v=%b",
                 k, grant4, sel4, busy4, valid4, e.grant, e.sel, e.busy, e.valid);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] tbl [5];
    exp_t e;
    tbl = '{16'b1_0100_0000_1_0100_0_1,
            16'b0_0101_0000_1_0000_0_0,
            16'b1_0101_0000_0_0001_0_1,
            16'b1_0101_0101_1_0001_0_1,
            16'b1_0101_0000_0_0100_0_1};
    for (int k = 0; k < 5; k++) begin
      drive_row4(tbl[k]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if ({grant4, sel4, busy4, valid4} !== e)
        $display("FAIL reset_mid row %0d: got g=%b s=%0d b=%b v=%b, want g=%b s=%0d b=%b v=%b",
                 k, grant4, sel4, busy4, valid4, e.grant, e.sel, e.busy, e.valid);
      else n_pass++;
    end
  endtask

  // Single-requester instance; row layout {req, tail, ready, exp_grant, exp_busy, exp_valid}.
  task automatic test_one_requester();
    logic [5:0] tbl [5];
    logic [5:0] r;
    exp_t e;
    exp_t x;
    tbl = '{6'b1_0_1_1_0_1,
            6'b1_1_1_1_1_1,
            6'b1_0_1_1_0_1,
            6'b1_1_1_1_1_1,
            6'b0_0_1_0_0_0};
    for (int k = 0; k < 5; k++) begin
      r = tbl[k];
      @(posedge clk);
      #1;
      {req1, tail1, ready1} = r[5:3];
      x.grant = {3'b000, r[2]};
      x.sel   = 2'd0;
      x.busy  = r[1];
      x.valid = r[0];
      sb_q.push_back(x);
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if ({3'b000, grant1, 1'b0, sel1, busy1, valid1} !== e)
        $display("FAIL one_req row %0d: got g=%b s=%0d b=%b v=%b, want g=%b s=%0d b=%b v=%b",
                 k, grant1, sel1, busy1, valid1, e.grant[0], e.sel, e.busy, e.valid);
      else n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    req4   = '0;
    tail4  = '0;
    ready4 = 1'b0;
    req1   = '0;
    tail1  = '0;
    ready1 = 1'b0;
    test_reset();
    test_single_flit();
    test_multi_flit();
    test_stall();
    test_reset_mid_packet();
    @(posedge clk);
    #1;
    req4   = '0;
    tail4  = '0;
    ready4 = 1'b0;
    test_one_requester();
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
